// File: rtl/intrusion_pkg.sv
// Shared definitions for the slow-signal monitors: measurement FSM states and
// the default no-edge timeout.
package intrusion_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE,
    ST_LOST
  } state_t;

  localparam int DEF_TIMEOUT = 120_000_000;

endpackage

// File: rtl/heartbeat_period_meter_if.sv
// Result channel of the period meter.
interface heartbeat_period_meter_if #(
  parameter int CNT_W = 28
) ();
  // Valid/ready: the producer raises period_valid with period_out and holds both
  // stable until a cycle where period_valid && period_ready (the transfer);
  // period_ready may change freely and never depends on period_valid.
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             period_ready;

  modport master (output period_out, output period_valid, input period_ready);
  modport slave  (input period_out, input period_valid, output period_ready);
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with a rising-edge detector. o_rise is the raw
// detection; o_pulse is the same event registered one cycle later.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise,
  output logic o_pulse
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;
  logic              r_pulse;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_dly   <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[STAGES-2:0], i_sig};
      r_dly   <= r_sync[STAGES-1];
      r_pulse <= o_rise;
    end
  end

  assign o_rise  = r_sync[STAGES-1] & ~r_dly;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/heartbeat_period_meter.sv
// Measures edge-to-edge period of a slow asynchronous pulse train, flags a
// missing edge as timeout and a result dropped under backpressure as overrun.
module heartbeat_period_meter
  import intrusion_pkg::*;
#(
  parameter int CNT_W       = 28,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int SYNC_STAGES = 2
) (
  input  logic   clk_in,
  input  logic   rst_n,
  input  logic   enable,
  input  logic   sig_in,
  output logic   edge_pulse,
  output logic   timeout,
  output logic   overrun,
  output state_t o_state,
  heartbeat_period_meter_if.master res
);

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [CNT_W-1:0] r_out, w_out_nx;
  logic             r_valid, w_valid_nx;
  logic             r_to, w_to_nx;
  logic             r_ovr, w_ovr_nx;
  logic             w_rise;
  logic             w_at_limit;
  logic             w_accept;
  logic             w_res_vld;
  logic [CNT_W-1:0] w_res;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .i_sig   (sig_in),
    .o_rise  (w_rise),
    .o_pulse (edge_pulse)
  );

  // Stored count of TIMEOUT-1 means this cycle completes TIMEOUT edge-free cycles.
  assign w_at_limit = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_accept   = r_valid & res.period_ready;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_to    <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_out   <= w_out_nx;
      r_valid <= w_valid_nx;
      r_to    <= w_to_nx;
      r_ovr   <= w_ovr_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_out_nx   = r_out;
    w_valid_nx = r_valid;
    w_to_nx    = r_to;
    w_ovr_nx   = r_ovr;
    w_res_vld  = 1'b0;
    w_res      = '0;
    if (!enable) begin
      w_state_nx = ST_IDLE;
      w_cnt_nx   = '0;
      w_valid_nx = 1'b0;
      w_to_nx    = 1'b0;
      w_ovr_nx   = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nx = ST_ARM;
          w_cnt_nx   = '0;
        end
        ST_ARM, ST_MEASURE: begin
          // An edge in the final cycle still wins, so results top out at TIMEOUT.
          if (w_rise) begin
            w_state_nx = ST_MEASURE;
            w_cnt_nx   = '0;
            w_res_vld  = (r_state == ST_MEASURE);
            w_res      = r_cnt + CNT_W'(1);
          end else if (w_at_limit) begin
            w_state_nx = ST_LOST;
            w_cnt_nx   = r_cnt + CNT_W'(1);
            w_to_nx    = 1'b1;
          end else begin
            w_cnt_nx   = r_cnt + CNT_W'(1);
          end
        end
        ST_LOST: begin
          if (w_rise) begin
            w_state_nx = ST_MEASURE;
            w_cnt_nx   = '0;
            w_to_nx    = 1'b0;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase

      if (w_res_vld) begin
        if (!r_valid || res.period_ready) begin
          w_out_nx   = w_res;
          w_valid_nx = 1'b1;
        end else begin
          w_ovr_nx   = 1'b1;
        end
      end else if (w_accept) begin
        w_valid_nx = 1'b0;
      end
    end
  end

  assign res.period_out   = r_out;
  assign res.period_valid = r_valid;
  assign timeout          = r_to;
  assign overrun          = r_ovr;
  assign o_state          = r_state;

endmodule

// File: tb/tb_heartbeat_period_meter.sv
// Bench for heartbeat_period_meter: directed table, hand-written corner cases
// and random traffic, all checked every cycle against a time-stamp based model.
module tb_heartbeat_period_meter;
  import intrusion_pkg::*;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;
  localparam int SYNC    = 2;

  localparam int MD_IDLE = 0;
  localparam int MD_ARM  = 1;
  localparam int MD_MEAS = 2;
  localparam int MD_LOST = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   rst_n, en, sig, rdy;
  logic   edge_pulse, timeout, overrun;
  state_t st;

  heartbeat_period_meter_if #(.CNT_W(CNT_W)) bus ();
  assign bus.period_ready = rdy;

  heartbeat_period_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT     (TIMEOUT),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_in     (clk),
    .rst_n      (rst_n),
    .enable     (en),
    .sig_in     (sig),
    .edge_pulse (edge_pulse),
    .timeout    (timeout),
    .overrun    (overrun),
    .o_state    (st),
    .res        (bus)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  // Works from sampled input history and time stamps of the last reference
  // point rather than a running counter.
  bit [SYNC:0]      h;
  int               mode;
  int               t_ref;
  bit               m_pulse, m_valid, m_to, m_ovr;
  logic [CNT_W-1:0] m_out;

  task automatic model_reset();
    h = '0; mode = MD_IDLE; t_ref = 0;
    m_pulse = 0; m_valid = 0; m_to = 0; m_ovr = 0; m_out = '0;
  endtask

  task automatic model_step();
    bit det, acc, have;
    int res_v;
    cyc++;
    det = h[SYNC-1] & ~h[SYNC];
    h   = {h[SYNC-1:0], sig};
    m_pulse = det;
    acc  = m_valid && (rdy === 1'b1);
    have = 0;
    res_v = 0;
    if (!en) begin
      mode = MD_IDLE; m_valid = 0; m_to = 0; m_ovr = 0;
    end else begin
      case (mode)
        MD_IDLE: begin mode = MD_ARM; t_ref = cyc; end
        MD_ARM: begin
          if (det) begin mode = MD_MEAS; t_ref = cyc; end
          else if (cyc - t_ref >= TIMEOUT) begin mode = MD_LOST; m_to = 1; end
        end
        MD_MEAS: begin
          if (det) begin have = 1; res_v = cyc - t_ref; t_ref = cyc; end
          else if (cyc - t_ref >= TIMEOUT) begin mode = MD_LOST; m_to = 1; end
        end
        default: begin
          if (det) begin mode = MD_MEAS; t_ref = cyc; m_to = 0; end
        end
      endcase
      if (have) begin
        if (!m_valid || rdy === 1'b1) begin m_out = CNT_W'(res_v); m_valid = 1; end
        else m_ovr = 1;
      end else if (acc) begin
        m_valid = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("edge_pulse",   32'(edge_pulse),       32'(m_pulse));
    chk("period_valid", 32'(bus.period_valid), 32'(m_valid));
    chk("period_out",   32'(bus.period_out),   32'(m_out));
    chk("timeout",      32'(timeout),          32'(m_to));
    chk("overrun",      32'(overrun),          32'(m_ovr));
  endtask

  task automatic pulse(input int w, input int gap);
    sig = 1'b1;
    repeat (w) tick();
    sig = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic rearm();
    en = 1'b0;
    repeat (2) tick();
    en = 1'b1;
    tick();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int unsigned      period;
    bit               ready;
    int unsigned      n_edges;
    int unsigned      tail;
    bit               exp_valid;
    logic [CNT_W-1:0] exp_out;
    bit               exp_ovr;
    bit               exp_to;
  } vec_t;

  vec_t vecs[8];
  int   cnt_left;

  initial begin
    vecs[0] = '{10, 1'b1, 4,  0, 1'b0, 16'd10, 1'b0, 1'b0};
    vecs[1] = '{10, 1'b0, 2,  0, 1'b1, 16'd10, 1'b0, 1'b0};
    vecs[2] = '{10, 1'b0, 3,  0, 1'b1, 16'd10, 1'b1, 1'b0};
    vecs[3] = '{7,  1'b0, 2,  0, 1'b1, 16'd7,  1'b0, 1'b0};
    vecs[4] = '{64, 1'b0, 2,  0, 1'b1, 16'd64, 1'b0, 1'b0};
    vecs[5] = '{65, 1'b0, 2,  0, 1'b0, 16'd0,  1'b0, 1'b0};
    vecs[6] = '{20, 1'b1, 1, 70, 1'b0, 16'd0,  1'b0, 1'b1};
    vecs[7] = '{10, 1'b1, 0, 70, 1'b0, 16'd0,  1'b0, 1'b1};

    rst_n = 1'b0; en = 1'b0; sig = 1'b0; rdy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pulse", 32'(edge_pulse),       32'd0);
    chk("rst_valid", 32'(bus.period_valid), 32'd0);
    chk("rst_out",   32'(bus.period_out),   32'd0);
    chk("rst_to",    32'(timeout),          32'd0);
    chk("rst_ovr",   32'(overrun),          32'd0);
    chk("rst_state", 32'(st),               32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (3) tick();

    for (int v = 0; v < 8; v++) begin
      rdy = 1'b0;
      rearm();
      rdy = vecs[v].ready;
      for (int e = 0; e < int'(vecs[v].n_edges); e++) pulse(2, int'(vecs[v].period) - 2);
      repeat (vecs[v].tail) tick();
      chk($sformatf("tbl%0d_valid", v), 32'(bus.period_valid), 32'(vecs[v].exp_valid));
      chk($sformatf("tbl%0d_ovr", v),   32'(overrun),          32'(vecs[v].exp_ovr));
      chk($sformatf("tbl%0d_to", v),    32'(timeout),          32'(vecs[v].exp_to));
      if (vecs[v].exp_valid)
        chk($sformatf("tbl%0d_out", v), 32'(bus.period_out), 32'(vecs[v].exp_out));
    end

    // Lost heartbeat, recovery edge gives no result, next period is 12.
    rdy = 1'b0;
    rearm();
    pulse(2, 98);
    chk("lost_to", 32'(timeout), 32'd1);
    pulse(2, 10);
    chk("lost_clear_to", 32'(timeout), 32'd0);
    chk("lost_no_result", 32'(bus.period_valid), 32'd0);
    sig = 1'b1;
    repeat (3) tick();
    sig = 1'b0;
    chk("lost_next_valid", 32'(bus.period_valid), 32'd1);
    chk("lost_next_out", 32'(bus.period_out), 32'd12);
    repeat (5) tick();

    // Accept in the same cycle as a new completion: 10 then 7.
    rdy = 1'b0;
    rearm();
    pulse(2, 8);
    pulse(2, 5);
    chk("coin_first", 32'(bus.period_out), 32'd10);
    sig = 1'b1;
    repeat (2) tick();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    sig = 1'b0;
    chk("coin_out", 32'(bus.period_out), 32'd7);
    chk("coin_valid", 32'(bus.period_valid), 32'd1);
    chk("coin_ovr", 32'(overrun), 32'd0);
    repeat (5) tick();

    // Enable dropped with a pending result; re-enable re-arms.
    rearm();
    pulse(2, 8);
    pulse(2, 8);
    chk("dis_pre_valid", 32'(bus.period_valid), 32'd1);
    en = 1'b0;
    tick();
    chk("dis_valid", 32'(bus.period_valid), 32'd0);
    chk("dis_state", 32'(st), 32'(ST_IDLE));
    en = 1'b1;
    tick();
    pulse(2, 8);
    chk("reen_first_edge", 32'(bus.period_valid), 32'd0);
    pulse(2, 8);
    chk("reen_valid", 32'(bus.period_valid), 32'd1);
    chk("reen_out", 32'(bus.period_out), 32'd10);

    // Asynchronous reset while a result is pending.
    pulse(2, 8);
    chk("arst_pre_valid", 32'(bus.period_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.period_valid), 32'd0);
    chk("arst_out",   32'(bus.period_out),   32'd0);
    chk("arst_to",    32'(timeout),          32'd0);
    chk("arst_ovr",   32'(overrun),          32'd0);
    chk("arst_pulse", 32'(edge_pulse),       32'd0);
    chk("arst_state", 32'(st),               32'(ST_IDLE));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pulse(2, 8);
    chk("arst_first_edge", 32'(bus.period_valid), 32'd0);
    pulse(2, 8);
    chk("arst_second_out", 32'(bus.period_out), 32'd10);

    // Random traffic against the model.
    cnt_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (cnt_left == 0) begin
        sig = ~sig;
        cnt_left = sig ? $urandom_range(1, 3) : $urandom_range(1, 80);
      end
      cnt_left--;
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
